fft_peak_finder: RTL and testbench

Streaming stage between the FFT core's output and the tone-detection FSM. Consumes one complex FFT bin per valid cycle and computes |X|² per bin. Tracks the largest-magnitude bin inside a configurable search window and the total in-window energy. Emits one registered result per frame, so the downstream tone classifier receives a bin index, a peak magnitude and a frame energy instead of raw spectra.

---
 rtl/fft_peak_finder.sv | 151 +++++++++++++++
 tb/tb_fft_peak_finder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_finder.sv
// fft_peak_finder: streaming |X|^2 peak and energy tracker for one FFT frame.
// Takes one complex bin per valid cycle, squares it over a three-stage
// pipeline, tracks the strongest bin and the summed energy inside
// [MIN_BIN, MAX_BIN], and emits one registered result per frame.
// Ports:
//   clk_in, rst_in     clock and synchronous active-high reset
//   fft_valid_in       a bin is present on fft_data_in
//   fft_last_in        marks the final bin of the frame
//   fft_data_in        {re[31:16], im[15:0]}, two's-complement
//   fft_ready_out      always 1, the block never stalls
//   peak_valid_out     one-cycle pulse: peak/energy outputs are new
//   peak_bin_out       index of the strongest in-window bin
//   peak_mag_out       re^2+im^2 of that bin
//   frame_energy_out   sum of re^2+im^2 over the window
//   frame_err_out      one-cycle pulse: frame length was not NFFT
module fft_peak_finder #(
  parameter int unsigned NFFT    = 1024,
  parameter int unsigned BIN_W   = 10,
  parameter int unsigned MIN_BIN = 1,
  parameter int unsigned MAX_BIN = 511
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  fft_valid_in,
  input  logic                  fft_last_in,
  input  logic [31:0]           fft_data_in,
  output logic                  fft_ready_out,
  output logic                  peak_valid_out,
  output logic [BIN_W-1:0]      peak_bin_out,
  output logic [31:0]           peak_mag_out,
  output logic [BIN_W+31:0]     frame_energy_out,
  output logic                  frame_err_out
);

  localparam int unsigned EN_W = BIN_W + 32;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NFFT - 1);
  localparam logic [BIN_W-1:0] MIN_B    = BIN_W'(MIN_BIN);
  localparam logic [BIN_W-1:0] MAX_B    = BIN_W'(MAX_BIN);

  // Per-sample tags that travel alongside the datapath.
  typedef struct packed {
    logic             last;   // sample closes the frame (good or bad)
    logic             err;    // frame closed with the wrong length
    logic             first;  // bin 0 of a frame
    logic             win;    // bin lies inside the search window
    logic [BIN_W-1:0] bin;
  } tag_t;

  logic [BIN_W-1:0] bin_cnt;
  logic             at_end;
  tag_t             in_tag;

  logic               s1_valid, s2_valid, s3_valid;
  tag_t               s1_tag, s2_tag, s3_tag;
  logic signed [15:0] s1_re, s1_im;
  logic [31:0]        s2_re2, s2_im2;
  logic [31:0]        s3_mag;
  logic signed [31:0] re_sq, im_sq;

  logic [31:0]      best_mag, best_mag_n, base_mag;
  logic [BIN_W-1:0] best_bin, best_bin_n, base_bin;
  logic [EN_W-1:0]  energy, energy_n, base_energy;

  assign fft_ready_out = 1'b1;

  // Input tagging: a frame ends on last or on reaching bin NFFT-1; a mismatch is an error.
  always_comb begin
    at_end       = (bin_cnt == LAST_BIN);
    in_tag.last  = fft_last_in | at_end;
    in_tag.err   = fft_last_in ^ at_end;
    in_tag.first = (bin_cnt == '0);
    in_tag.win   = (bin_cnt >= MIN_B) && (bin_cnt <= MAX_B);
    in_tag.bin   = bin_cnt;
  end

  // Squares: (-32768)^2 = 2^30 still fits the signed 32-bit product.
  always_comb begin
    re_sq = 32'(s1_re) * 32'(s1_re);
    im_sq = 32'(s1_im) * 32'(s1_im);
  end

  // Running max/energy; a first-bin sample restarts both so frames in flight stay isolated.
  always_comb begin
    base_mag    = s3_tag.first ? '0    : best_mag;
    base_bin    = s3_tag.first ? MIN_B : best_bin;
    base_energy = s3_tag.first ? '0    : energy;
    best_mag_n  = base_mag;
    best_bin_n  = base_bin;
    energy_n    = base_energy;
    if (s3_tag.win) begin
      energy_n = base_energy + EN_W'(s3_mag);
      if (s3_mag > base_mag) begin  // strict: ties keep the lower bin
        best_mag_n = s3_mag;
        best_bin_n = s3_tag.bin;
      end
    end
  end

  // Control state: counter, stage valids (drain every cycle) and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bin_cnt          <= '0;
      s1_valid         <= 1'b0;
      s2_valid         <= 1'b0;
      s3_valid         <= 1'b0;
      peak_valid_out   <= 1'b0;
      frame_err_out    <= 1'b0;
      peak_bin_out     <= '0;
      peak_mag_out     <= '0;
      frame_energy_out <= '0;
    end else begin
      s1_valid       <= fft_valid_in;
      s2_valid       <= s1_valid;
      s3_valid       <= s2_valid;
      peak_valid_out <= s3_valid & s3_tag.last & ~s3_tag.err;
      frame_err_out  <= s3_valid & s3_tag.last & s3_tag.err;
      if (fft_valid_in) begin
        bin_cnt <= in_tag.last ? '0 : bin_cnt + BIN_W'(1);
      end
      if (s3_valid && s3_tag.last && !s3_tag.err) begin
        peak_bin_out     <= best_bin_n;
        peak_mag_out     <= best_mag_n;
        frame_energy_out <= energy_n;
      end
    end
  end

  // Datapath registers: loaded only with a valid sample, qualified by the valids above.
  always_ff @(posedge clk_in) begin
    if (fft_valid_in) begin
      s1_tag <= in_tag;
      s1_re  <= fft_data_in[31:16];
      s1_im  <= fft_data_in[15:0];
    end
    if (s1_valid) begin
      s2_tag <= s1_tag;
      s2_re2 <= re_sq;
      s2_im2 <= im_sq;
    end
    if (s2_valid) begin
      s3_tag <= s2_tag;
      s3_mag <= s2_re2 + s2_im2;
    end
    if (s3_valid) begin
      best_mag <= best_mag_n;
      best_bin <= best_bin_n;
      energy   <= energy_n;
    end
  end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Self-checking bench for fft_peak_finder: a table of whole-frame vectors with
// hand-computed results, plus a mid-frame reset sequence. A monitor matches
// every pulse against the expectation queue and checks outputs hold between pulses.
module tb_fft_peak_finder;

  localparam int unsigned NFFT    = 1024;
  localparam int unsigned BIN_W   = 10;
  localparam int unsigned MIN_BIN = 1;
  localparam int unsigned MAX_BIN = 511;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               valid = 1'b0;
  logic               last = 1'b0;
  logic [31:0]        data = '0;
  logic               ready;
  logic               pv;
  logic [BIN_W-1:0]   pbin;
  logic [31:0]        pmag;
  logic [BIN_W+31:0]  penergy;
  logic               ferr;

  always #5 clk = ~clk;

  fft_peak_finder #(
    .NFFT(NFFT), .BIN_W(BIN_W), .MIN_BIN(MIN_BIN), .MAX_BIN(MAX_BIN)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .fft_valid_in(valid),
    .fft_last_in(last),
    .fft_data_in(data),
    .fft_ready_out(ready),
    .peak_valid_out(pv),
    .peak_bin_out(pbin),
    .peak_mag_out(pmag),
    .frame_energy_out(penergy),
    .frame_err_out(ferr)
  );

  // One frame: up to three nonzero bins (bin -1 = unused) and the expected result.
  typedef struct {
    int     len;
    bit     no_last;
    bit     gaps;
    int     b0; int r0; int i0;
    int     b1; int r1; int i1;
    int     b2; int r2; int i2;
    bit     err;
    int     bin;
    longint mag;
    longint energy;
  } vec_t;

  typedef struct {
    bit                err;
    logic [BIN_W-1:0]  bin;
    logic [31:0]       mag;
    logic [BIN_W+31:0] energy;
    int                t;
    bit                exact;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic rst_q = 1'b0;
  bit   armed = 1'b0;
  exp_t me;
  logic [BIN_W-1:0]  cur_bin = '0;
  logic [31:0]       cur_mag = '0;
  logic [BIN_W+31:0] cur_energy = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input int len, input bit no_last, input bit gaps,
                              input int b0, input int r0, input int i0,
                              input int b1, input int r1, input int i1,
                              input int b2, input int r2, input int i2,
                              input bit err, input int bin, input longint mag,
                              input longint energy);
    vec_t v;
    v.len = len; v.no_last = no_last; v.gaps = gaps;
    v.b0 = b0; v.r0 = r0; v.i0 = i0;
    v.b1 = b1; v.r1 = r1; v.i1 = i1;
    v.b2 = b2; v.r2 = r2; v.i2 = i2;
    v.err = err; v.bin = bin; v.mag = mag; v.energy = energy;
    return v;
  endfunction

  function automatic logic [31:0] data_for(input vec_t v, input int i);
    if (i == v.b0) return {16'(v.r0), 16'(v.i0)};
    if (i == v.b1) return {16'(v.r1), 16'(v.i1)};
    if (i == v.b2) return {16'(v.r2), 16'(v.i2)};
    return 32'd0;
  endfunction

  task automatic send(input bit v, input bit l, input logic [31:0] d);
    @(posedge clk);
    #1;
    valid = v;
    last  = l;
    data  = d;
  endtask

  // Drive one frame and queue its expected pulse (accept edge + 3).
  task automatic run_frame(input vec_t v);
    int   n;
    exp_t e;
    n = v.no_last ? int'(NFFT) : v.len;
    for (int i = 0; i < n; i++) begin
      if (v.gaps) begin
        while ($urandom_range(0, 3) == 0) send(1'b0, 1'b0, 32'd0);
      end
      send(1'b1, !v.no_last && (i == n - 1), data_for(v, i));
    end
    e.err    = v.err;
    e.bin    = BIN_W'(v.bin);
    e.mag    = 32'(v.mag);
    e.energy = (BIN_W+32)'(v.energy);
    e.t      = cyc + 4;
    e.exact  = !v.gaps;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    rst_q <= rst;
    cyc   <= cyc + 1;
  end

  // Monitor: reset values, pulse contents/latency, and hold between pulses.
  always @(negedge clk) begin
    if (rst_q) begin
      armed = 1'b1;
      chk("rst_ready", longint'(ready), 1);
      chk("rst_peak_valid", longint'(pv), 0);
      chk("rst_frame_err", longint'(ferr), 0);
      chk("rst_bin", longint'(pbin), 0);
      chk("rst_mag", longint'(pmag), 0);
      chk("rst_energy", longint'(penergy), 0);
      cur_bin = '0; cur_mag = '0; cur_energy = '0;
    end else if (armed) begin
      chk("ready", longint'(ready), 1);
      if (pv || ferr) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", longint'({pv, ferr}), 0);
        end else begin
          me = q.pop_front();
          chk("pulse_valid", longint'(pv), longint'(!me.err));
          chk("pulse_err", longint'(ferr), longint'(me.err));
          chk("peak_bin", longint'(pbin), longint'(me.bin));
          chk("peak_mag", longint'(pmag), longint'(me.mag));
          chk("frame_energy", longint'(penergy), longint'(me.energy));
          if (me.exact) chk("latency", longint'(cyc), longint'(me.t));
          else          chk("latency_max", longint'(cyc <= me.t), 1);
          cur_bin = me.bin; cur_mag = me.mag; cur_energy = me.energy;
        end
      end else begin
        chk("hold_bin", longint'(pbin), longint'(cur_bin));
        chk("hold_mag", longint'(pmag), longint'(cur_mag));
        chk("hold_energy", longint'(penergy), longint'(cur_energy));
      end
    end
  end

  vec_t vecs[11];

  initial begin
    //              len  nl gp  b0   r0      i0      b1   r1      i1      b2  r2  i2   err bin  mag             energy
    vecs[0]  = mk(1024, 0, 0, 100, 1000, 0, -1, 0, 0, -1, 0, 0, 0, 100, 1000000, 1000000);
    vecs[1]  = mk(1024, 0, 0, 0, 32767, 32767, 20, 0, -300, 40, 0, -300, 0, 20, 90000, 180000);
    vecs[2]  = mk(1024, 0, 0, 511, -32768, -32768, 512, -32768, -32768, -1, 0, 0,
                  0, 511, 64'd2147483648, 64'd2147483648);
    vecs[3]  = mk(501, 0, 0, 50, 5, 5, -1, 0, 0, -1, 0, 0,
                  1, 511, 64'd2147483648, 64'd2147483648);
    vecs[4]  = mk(1024, 0, 0, 3, 3, 4, -1, 0, 0, -1, 0, 0, 0, 3, 25, 25);
    vecs[5]  = mk(1024, 0, 1, 7, 100, -100, 600, 1000, 1000, -1, 0, 0, 0, 7, 20000, 20000);
    vecs[6]  = mk(1024, 0, 1, 300, -50, 20, 301, 10, 10, -1, 0, 0, 0, 300, 2900, 3100);
    vecs[7]  = mk(1024, 0, 0, -1, 0, 0, -1, 0, 0, -1, 0, 0, 0, 1, 0, 0);
    vecs[8]  = mk(1024, 1, 0, 10, 7, 7, -1, 0, 0, -1, 0, 0, 1, 1, 0, 0);
    vecs[9]  = mk(1024, 0, 0, 1, 10, 0, 511, 0, 10, -1, 0, 0, 0, 1, 100, 200);
    vecs[10] = mk(1024, 0, 0, 255, -1, -1, -1, 0, 0, -1, 0, 0, 0, 255, 2, 2);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 10; k++) run_frame(vecs[k]);

    // Partial frame with a large bin, killed by a one-cycle reset at bin 600.
    for (int i = 0; i < 600; i++) begin
      send(1'b1, 1'b0, (i == 5) ? {16'(20000), 16'(0)} : 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1; valid = 1'b0; last = 1'b0; data = '0;
    @(posedge clk);
    #1 rst = 1'b0;

    run_frame(vecs[10]);
    send(1'b0, 1'b0, 32'd0);

    for (int w = 0; w < 20 && q.size() != 0; w++) @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL pulse_timeout: %0d expected pulses missing, required 0", q.size());
    end
    repeat (4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
